// File: rtl/clint.sv
// Core-local interruptor: msip, 64-bit mtime/mtimecmp, timer compare. Optional mtime prescaler under CLINT_RTC_DIV_EN.
// One-cycle response after accept; valid ignored while responding (one transaction per two cycles).
`timescale 1ns/1ps

module clint #(
    parameter int RTC_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clint_valid,
    input  logic        clint_instr,
    input  logic [31:0] clint_addr,
    input  logic [31:0] clint_wdata,
    input  logic [3:0]  clint_wstrb,
    output logic [31:0] clint_rdata,
    output logic        clint_ready,
    output logic        clint_msip,
    output logic        clint_mtip,
    output logic [63:0] clint_mtime
);

    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [13:0] W_MSIP    = 14'h0000;
    localparam logic [13:0] W_CMP_LO  = 14'h1000;
    localparam logic [13:0] W_CMP_HI  = 14'h1001;
    localparam logic [13:0] W_TIME_LO = 14'h2FFE;
    localparam logic [13:0] W_TIME_HI = 14'h2FFF;

    state_t      state;
    logic        msip_q;
    logic [63:0] mtime_q;
    logic [63:0] mtimecmp_q;
    logic [63:0] mtime_nxt;
    logic [31:0] rd_mux;
    logic [13:0] word;
    logic        accept;
    logic        wr;
    logic        tick;

    logic [18:0] unused_bits;
    assign unused_bits = {clint_instr, clint_addr[31:16], clint_addr[1:0]};

    assign word   = clint_addr[15:2];
    assign accept = (state == IDLE) && clint_valid;
    assign wr     = accept && (clint_wstrb != 4'b0000);

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = data[b*8 +: 8];
        end
        return res;
    endfunction

`ifdef CLINT_RTC_DIV_EN
    logic [15:0] presc_q;

    assign tick = (presc_q == 16'(RTC_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 16'd1;
        end
    end
`else
    logic [15:0] unused_div;
    assign unused_div = 16'(RTC_DIV);
    assign tick       = 1'b1;
`endif

    always_comb begin
        rd_mux = 32'h0;
        case (word)
            W_MSIP:    rd_mux = {31'h0, msip_q};
            W_CMP_LO:  rd_mux = mtimecmp_q[31:0];
            W_CMP_HI:  rd_mux = mtimecmp_q[63:32];
            W_TIME_LO: rd_mux = mtime_q[31:0];
            W_TIME_HI: rd_mux = mtime_q[63:32];
            default:   rd_mux = 32'h0;
        endcase
    end

    // A software write to either mtime half suppresses the increment for that cycle.
    always_comb begin
        mtime_nxt = mtime_q;
        if (wr && (word == W_TIME_LO || word == W_TIME_HI)) begin
            if (word == W_TIME_LO) mtime_nxt[31:0]  = merge(mtime_q[31:0], clint_wdata, clint_wstrb);
            else                   mtime_nxt[63:32] = merge(mtime_q[63:32], clint_wdata, clint_wstrb);
        end else if (tick) begin
            mtime_nxt = mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            clint_ready <= 1'b0;
            clint_rdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (clint_valid) begin
                        state       <= RESP;
                        clint_ready <= 1'b1;
                        clint_rdata <= rd_mux;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    clint_ready <= 1'b0;
                    clint_rdata <= 32'h0;
                end
                default: begin
                    state       <= IDLE;
                    clint_ready <= 1'b0;
                    clint_rdata <= 32'h0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msip_q     <= 1'b0;
            mtime_q    <= 64'h0;
            mtimecmp_q <= '1;
        end else begin
            mtime_q <= mtime_nxt;
            if (wr) begin
                if (word == W_MSIP && clint_wstrb[0]) msip_q <= clint_wdata[0];
                if (word == W_CMP_LO)
                    mtimecmp_q[31:0]  <= merge(mtimecmp_q[31:0], clint_wdata, clint_wstrb);
                if (word == W_CMP_HI)
                    mtimecmp_q[63:32] <= merge(mtimecmp_q[63:32], clint_wdata, clint_wstrb);
            end
        end
    end

    assign clint_msip  = msip_q;
    assign clint_mtime = mtime_q;
    assign clint_mtip  = (mtime_q >= mtimecmp_q);

endmodule

// File: tb/tb_clint.sv
// Scoreboarded bench for clint: directed register accesses, timer compare, wrap, reset abort, throughput.
`timescale 1ns/1ps

module tb_clint;

    logic        clk;
    logic        rst_n;
    logic        clint_valid;
    logic        clint_instr;
    logic [31:0] clint_addr;
    logic [31:0] clint_wdata;
    logic [3:0]  clint_wstrb;
    logic [31:0] clint_rdata;
    logic        clint_ready;
    logic        clint_msip;
    logic        clint_mtip;
    logic [63:0] clint_mtime;

    typedef struct {
        bit          chk;
        logic [31:0] exp;
        string       name;
    } sb_t;

    sb_t  sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc;

    clint #(.RTC_DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clint_valid (clint_valid),
        .clint_instr (clint_instr),
        .clint_addr  (clint_addr),
        .clint_wdata (clint_wdata),
        .clint_wstrb (clint_wstrb),
        .clint_rdata (clint_rdata),
        .clint_ready (clint_ready),
        .clint_msip  (clint_msip),
        .clint_mtip  (clint_mtip),
        .clint_mtime (clint_mtime)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since the last reset release; equals mtime while nothing writes it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse consumes one scoreboard entry.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (rst_n && clint_ready) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ready: got ready=1 with rdata 0x%0h, expected no response", clint_rdata);
                end else begin
                    e = sb_q.pop_front();
                    if (e.chk) check(e.name, {32'h0, clint_rdata}, {32'h0, e.exp});
                end
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after the response cycle.
    task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                       input bit chk, input logic [31:0] exp, input string name);
        sb_t e;
        e.chk = chk;
        e.exp = exp;
        e.name = name;
        sb_q.push_back(e);
        clint_valid = 1'b1;
        clint_addr  = addr;
        clint_wdata = wdata;
        clint_wstrb = wstrb;
        @(negedge clk);
        check({name, "_ready_hi"}, {63'h0, clint_ready}, 64'd1);
        clint_valid = 1'b0;
        clint_wstrb = 4'b0000;
        @(negedge clk);
        check({name, "_ready_lo"}, {63'h0, clint_ready}, 64'd0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                      input string name);
        txn(addr, wdata, wstrb, 1'b0, 32'h0, name);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        txn(addr, 32'h0, 4'b0000, 1'b1, exp, name);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish within 200us");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        int guard;
        rst_n       = 1'b0;
        clint_valid = 1'b0;
        clint_instr = 1'b0;
        clint_addr  = 32'h0;
        clint_wdata = 32'h0;
        clint_wstrb = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_ready", {63'h0, clint_ready}, 64'd0);
        check("rst_rdata", {32'h0, clint_rdata}, 64'd0);
        check("rst_msip",  {63'h0, clint_msip},  64'd0);
        check("rst_mtip",  {63'h0, clint_mtip},  64'd0);
        check("rst_mtime", clint_mtime, 64'd0);
        rst_n = 1'b1;

`ifndef CLINT_RTC_DIV_EN
        // Accept on the 20th edge after release samples mtime=19.
        repeat (19) @(negedge clk);
        check("mtime_at19", clint_mtime, 64'd19);
        rd(32'h0000_BFF8, 32'd19, "rd_mtime_lo");
        rd(32'h0000_BFFC, 32'd0,  "rd_mtime_hi");

        wr(32'h0000_4004, 32'h0,  4'b1111, "wr_cmp_hi0");
        wr(32'h0000_4000, 32'h40, 4'b1111, "wr_cmp_lo40");
        rd(32'h0000_4000, 32'h40, "rd_cmp_lo");
        check("mtip_before", {63'h0, clint_mtip}, 64'd0);
        guard = 0;
        while (cyc != 63 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("wait_cyc63", {32'h0, 32'(cyc)}, 64'd63);
        check("mtime_63", clint_mtime, 64'd63);
        check("mtip_at63", {63'h0, clint_mtip}, 64'd0);
        @(negedge clk);
        check("mtime_64", clint_mtime, 64'd64);
        check("mtip_at64", {63'h0, clint_mtip}, 64'd1);
        wr(32'h0000_4004, 32'hFFFF_FFFF, 4'b1111, "wr_cmp_hi_ff");
        check("mtip_cleared", {63'h0, clint_mtip}, 64'd0);
`endif

        wr(32'h0000_0000, 32'h1, 4'b1111, "wr_msip1");
        check("msip_set", {63'h0, clint_msip}, 64'd1);
        rd(32'h0000_0000, 32'h1, "rd_msip1");
        wr(32'h0000_0000, 32'hFFFF_FFFE, 4'b1111, "wr_msip0");
        check("msip_clr", {63'h0, clint_msip}, 64'd0);
        rd(32'h0000_0000, 32'h0, "rd_msip0");

`ifndef CLINT_RTC_DIV_EN
        wr(32'h0000_4000, 32'hFFFF_FFFF, 4'b1111, "wr_cmp_lo_ff");
        wr(32'h0000_BFFC, 32'hFFFF_FFFF, 4'b1111, "wr_time_hi");
        wr(32'h0000_BFF8, 32'hFFFF_FFFE, 4'b1111, "wr_time_lo");
        check("mtime_allones", clint_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        check("mtip_allones", {63'h0, clint_mtip}, 64'd1);
        @(negedge clk);
        check("mtime_wrap", clint_mtime, 64'd0);
        check("mtip_wrap", {63'h0, clint_mtip}, 64'd0);
        // Write on a tick edge: byte1 written, others hold 0, no increment, then +1 next edge.
        wr(32'h0000_BFF8, 32'h0000_AA00, 4'b0010, "wr_time_byte");
        check("mtime_write_vs_tick", clint_mtime, 64'h0000_0000_0000_AA01);
`endif

        // Reset while the response is pending: no pulse may follow.
        begin
            sb_t e;
            e.chk = 1'b1;
            e.exp = 32'h0;
            e.name = "aborted";
            sb_q.push_back(e);
        end
        clint_valid = 1'b1;
        clint_addr  = 32'h0;
        clint_wstrb = 4'b0000;
        @(posedge clk);
        #2;
        rst_n       = 1'b0;
        clint_valid = 1'b0;
        #1;
        check("abort_ready", {63'h0, clint_ready}, 64'd0);
        check("abort_rdata", {32'h0, clint_rdata}, 64'd0);
        check("abort_mtime", clint_mtime, 64'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (clint_ready) pulses++;
        end
        check("no_pulse_after_abort", {32'h0, 32'(pulses)}, 64'd0);

`ifdef CLINT_RTC_DIV_EN
        // Prescaler: one mtime tick per 4 edges from release.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("presc_mtime3", clint_mtime, 64'd0);
        @(negedge clk);
        check("presc_mtime4", clint_mtime, 64'd1);
        repeat (3) @(negedge clk);
        check("presc_mtime7", clint_mtime, 64'd1);
        @(negedge clk);
        check("presc_mtime8", clint_mtime, 64'd2);
`endif

        wr(32'h0000_4000, 32'h0000_AB00, 4'b0010, "wr_cmp_byte1");
        rd(32'h0000_4000, 32'hFFFF_ABFF, "rd_cmp_byte1");
        rd(32'h0000_4004, 32'hFFFF_FFFF, "rd_cmp_hi_rst");
        rd(32'h0000_4003, 32'hFFFF_ABFF, "rd_cmp_lowbits_ignored");
        wr(32'h0000_1234, 32'hFFFF_FFFF, 4'b1111, "wr_unmapped");
        rd(32'h0000_1234, 32'h0, "rd_unmapped");
        check("unmapped_msip", {63'h0, clint_msip}, 64'd0);
        wr(32'hABCD_0000, 32'h1, 4'b0001, "wr_msip_hi_addr");
        check("msip_hi_addr", {63'h0, clint_msip}, 64'd1);

        // Valid held high: responses on every other cycle.
        for (int i = 0; i < 4; i++) begin
            sb_t e;
            e.chk = 1'b1;
            e.exp = 32'h1;
            e.name = "rd_hold";
            sb_q.push_back(e);
        end
        clint_valid = 1'b1;
        clint_addr  = 32'h0;
        clint_wstrb = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("hold_ready_pattern", {63'h0, clint_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
        end
        clint_valid = 1'b0;
        @(negedge clk);
        check("hold_ready_end", {63'h0, clint_ready}, 64'd0);
        check("sb_drain", {32'h0, 32'(sb_q.size())}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
